ema_channel_scheduler: RTL and testbench
========================================

// Module: ema_channel_scheduler
// PURPOSE
//  Time-shares one LUT-based EMA datapath (alpha ROM on x, beta ROM on y_prev) among NCH input channels.
//  Arbitrates channels round-robin and holds per-channel y_prev state.
//  Drives the two LUT address buses, forms y = alpha + beta and returns tagged results.
//  Backpressure is supported on both the input and output sides.
// PARAMETERS
//  WIDTH  8   sample width: x, y and the LUT address width
//  NCH    4   number of channels (>=2); CHW = $clog2(NCH) is a localparam
//  LUT_W  16  width of the alpha and beta LUT data
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous, active-high
//  in_valid    in   NCH        per-channel sample valid
//  in_data     in   NCH*WIDTH  channel i in bits [i*WIDTH +: WIDTH]
//  in_ready    out  NCH        one-hot grant; a handshake completes when in_valid[i] & in_ready[i]
//  ch_clear    in   NCH        per-channel pulse; sets y_state[i] to 0
//  lut_x_addr  out  WIDTH      address to the alpha LUT
//  lut_y_addr  out  WIDTH      address to the beta LUT
//  lut_alpha   in   LUT_W      alpha LUT data, combinational from lut_x_addr
//  lut_beta    in   LUT_W      beta LUT data, combinational from lut_y_addr
//  out_valid   out  1          result valid
//  out_ch      out  CHW        channel tag of the result
//  out_data    out  WIDTH      filtered result y
//  out_ready   in   1          downstream accept
//  busy        out  1          high when state != IDLE
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, out_valid=0, out_data=0, out_ch=0, busy=0, all y_state=0.
//   - x_reg=0, ch_reg=0, rr_ptr=NCH-1, so channel 0 wins the first grant.
//  FSM IDLE -> LOOKUP -> OUTPUT -> IDLE.
//  IDLE:
//   - If any in_valid is high, grant the first requester found searching from rr_ptr+1 with wraparound.
//   - in_ready is combinational, one-hot, and asserted only in IDLE to the granted channel.
//   - On the grant edge: x_reg<=in_data[g], ch_reg<=g, rr_ptr<=g, go to LOOKUP.
//   - If no channel requests, stay in IDLE; in_ready=0.
//  LOOKUP:
//   - sum = lut_alpha + lut_beta (LUT_W+1 bits); y = sum[WIDTH-1:0], truncated, no saturation.
//   - On the edge: out_data<=y, out_ch<=ch_reg, out_valid<=1, y_state[ch_reg]<=y, go to OUTPUT.
//  OUTPUT:
//   - Hold out_valid, out_data and out_ch stable until out_ready=1.
//   - On the accept edge: out_valid<=0, go to IDLE.
//   - No new grant is issued in the accept cycle.
//  LUT addressing:
//   - lut_x_addr = x_reg at all times.
//   - lut_y_addr = y_state[ch_reg] at all times. Values are only consumed in LOOKUP.
//  Throughput and latency:
//   - Max 1 sample per 3 cycles.
//   - Grant edge to out_valid high is 2 edges.
//  ch_clear[i]:
//   - y_state[i]<=0 on the next edge, in any state.
//   - If the clear coincides with the LOOKUP writeback to the same channel, the clear wins: y_state=0.
//   - In that case out_data still carries the computed y.
//   - A clear never aborts an in-flight sample.
//  Simultaneous requests: exactly one grant per IDLE cycle. Unserved channels keep in_valid and wait.
//  Reset mid-operation: the in-flight sample is dropped, no output is produced, all state returns to reset values.
// TESTING (bench LUT model: alpha(x)=x>>2, beta(y)=(3*y)>>2, WIDTH=8, NCH=4)
//  1. Reset, then ch0 x=200 -> out_ch=0, out_data=50. Next ch0 x=200 -> out_data=87 (50+37).
//  2. All 4 in_valid held, out_ready=1 -> grants 0,1,2,3,0 in order; one in_ready pulse every 3 cycles.
//  3. out_ready=0 for 5 cycles while OUTPUT -> out_valid/out_data/out_ch stable, in_ready=0, no grant.
//  4. Forced lut_alpha=16'hFFFF, lut_beta=16'h0002 -> out_data=8'h01; the next lookup of that channel sees lut_y_addr=8'h01.
//  5. ch1 holds y=87; pulse ch_clear[1]; ch1 x=200 -> out_data=50.
//     Clear coinciding with ch1 LOOKUP -> out_data computed normally, next ch1 sample uses y=0.
//  6. Assert reset during OUTPUT -> out_valid=0 and busy=0 immediately; the following ch0 x=200 -> 50.

Source files
------------

// File: rtl/ema_channel_scheduler.sv
// rtl/ema_channel_scheduler.sv - round-robin time-sharing of one LUT-based EMA datapath among NCH channels
// Holds per-channel y_prev state, drives the alpha/beta LUT addresses and returns channel-tagged results.
module ema_channel_scheduler #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int LUT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCH-1:0]             in_valid,
  input  logic [NCH*WIDTH-1:0]       in_data,
  output logic [NCH-1:0]             in_ready,
  input  logic [NCH-1:0]             ch_clear,
  output logic [WIDTH-1:0]           lut_x_addr,
  output logic [WIDTH-1:0]           lut_y_addr,
  input  logic [LUT_W-1:0]           lut_alpha,
  input  logic [LUT_W-1:0]           lut_beta,
  output logic                       out_valid,
  output logic [$clog2(NCH)-1:0]     out_ch,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic                       busy
);
  localparam int CHW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, LOOKUP, OUTPUT} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] x_reg;
  logic [CHW-1:0]   ch_reg;
  logic [CHW-1:0]   rr_ptr;
  logic [WIDTH-1:0] y_state [NCH];

  logic             found;
  logic [CHW-1:0]   grant;
  logic [LUT_W:0]   sum;
  logic [WIDTH-1:0] y;
  logic             unused_sum_hi;

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = CHW'(idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (state == IDLE && found)
      in_ready[grant] = 1'b1;
  end

  assign sum           = {1'b0, lut_alpha} + {1'b0, lut_beta};
  assign y             = sum[WIDTH-1:0];
  assign unused_sum_hi = ^sum[LUT_W:WIDTH];

  assign lut_x_addr = x_reg;
  assign lut_y_addr = y_state[ch_reg];
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found)     next_state = LOOKUP;
      LOOKUP:                 next_state = OUTPUT;
      OUTPUT:  if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg     <= '0;
      ch_reg    <= '0;
      rr_ptr    <= CHW'(NCH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      for (int i = 0; i < NCH; i++)
        y_state[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            x_reg  <= in_data[grant*WIDTH +: WIDTH];
            ch_reg <= grant;
            rr_ptr <= grant;
          end
        end
        LOOKUP: begin
          out_data        <= y;
          out_ch          <= ch_reg;
          out_valid       <= 1'b1;
          y_state[ch_reg] <= y;
        end
        OUTPUT: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: ;
      endcase
      // Placed after the writeback so a coincident clear overrides it.
      for (int i = 0; i < NCH; i++)
        if (ch_clear[i])
          y_state[i] <= '0;
    end
  end

endmodule

// File: tb/tb_ema_channel_scheduler.sv
// tb/tb_ema_channel_scheduler.sv - directed self-checking bench for ema_channel_scheduler
// LUT model: alpha(x) = x>>2, beta(y) = (3*y)>>2, optionally forced to fixed values.
module tb_ema_channel_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  ch_clear;
  logic [7:0]  lut_x_addr;
  logic [7:0]  lut_y_addr;
  logic [15:0] lut_alpha;
  logic [15:0] lut_beta;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        force_lut;

  int errors = 0;
  int checks = 0;

  ema_channel_scheduler #(.WIDTH(8), .NCH(4), .LUT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ch_clear(ch_clear),
    .lut_x_addr(lut_x_addr), .lut_y_addr(lut_y_addr),
    .lut_alpha(lut_alpha), .lut_beta(lut_beta),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (force_lut) begin
      lut_alpha = 16'hFFFF;
      lut_beta  = 16'h0002;
    end else begin
      lut_alpha = {8'h00, lut_x_addr} >> 2;
      lut_beta  = ({8'h00, lut_y_addr} * 16'd3) >> 2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample through a single channel; optionally clears that channel during its LOOKUP cycle.
  task automatic do_sample(input int ch, input logic [7:0] x, input logic [7:0] yprev,
                           input logic [7:0] exp, input bit clr);
    int n;
    @(negedge clk);
    in_valid[ch] = 1'b1;
    in_data[ch*8 +: 8] = x;
    #1;
    n = 0;
    while (in_ready !== 4'(1 << ch) && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    check("grant", 32'(in_ready), 32'(4'(1 << ch)));
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
    @(negedge clk);
    check("lookup_out_valid", 32'(out_valid), 32'd0);
    check("lookup_busy", 32'(busy), 32'd1);
    check("lut_x_addr", 32'(lut_x_addr), 32'(x));
    check("lut_y_addr", 32'(lut_y_addr), 32'(yprev));
    if (clr) ch_clear[ch] = 1'b1;
    @(posedge clk); #1;
    ch_clear = '0;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_ch", 32'(out_ch), 32'(ch));
    check("out_data", 32'(out_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    reset = 1'b1; in_valid = '0; in_data = '0; ch_clear = '0;
    out_ready = 1'b1; force_lut = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_x_addr", 32'(lut_x_addr), 32'd0);
    check("rst_y_addr", 32'(lut_y_addr), 32'd0);
    reset = 1'b0;

    // Basic EMA on ch0
    do_sample(0, 8'd200, 8'd0, 8'd50, 1'b0);
    do_sample(0, 8'd200, 8'd50, 8'd87, 1'b0);

    // All channels requesting: round-robin 0,1,2,3,0 with a grant every 3 cycles
    do_reset();
    @(negedge clk);
    in_valid = 4'hF;
    in_data  = {8'd40, 8'd40, 8'd40, 8'd40};
    #1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      exp_rdy = (cyc % 3 == 0 && cyc <= 12) ? 4'(1 << ((cyc / 3) % 4)) : 4'b0;
      check("rr_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("rr_out_valid", 32'(out_valid), (cyc % 3 == 2) ? 32'd1 : 32'd0);
      if (cyc % 3 == 2) begin
        check("rr_out_ch", 32'(out_ch), 32'((cyc / 3) % 4));
        check("rr_out_data", 32'(out_data), (cyc == 14) ? 32'd17 : 32'd10);
      end
      @(posedge clk); #1;
      if (cyc == 12) in_valid = '0;
      @(negedge clk); #1;
    end

    // Output stall: hold result, no grant while OUTPUT or in the accept cycle
    out_ready = 1'b0;
    in_valid[2] = 1'b1;
    in_data[23:16] = 8'd0;
    #1;
    check("stall_grant", 32'(in_ready), 32'h4);
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    in_valid[3] = 1'b1;
    in_data[31:24] = 8'd0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'd7);
      check("stall_out_ch", 32'(out_ch), 32'd2);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      if (i < 4) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("accept_no_grant", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    check("post_accept_grant", 32'(in_ready), 32'h8);
    @(posedge clk); #1;
    in_valid[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ch3_out_ch", 32'(out_ch), 32'd3);
    check("ch3_out_data", 32'(out_data), 32'd7);
    @(posedge clk); #1;

    // Truncating sum: FFFF + 0002 -> 01
    force_lut = 1'b1;
    do_sample(1, 8'd100, 8'd10, 8'h01, 1'b0);
    force_lut = 1'b0;
    do_sample(1, 8'd0, 8'h01, 8'd0, 1'b0);

    // Channel clear in IDLE, then clear coinciding with LOOKUP writeback
    do_sample(1, 8'd200, 8'd0, 8'd50, 1'b0);
    do_sample(1, 8'd200, 8'd50, 8'd87, 1'b0);
    @(negedge clk);
    ch_clear[1] = 1'b1;
    @(posedge clk); #1;
    ch_clear = '0;
    @(negedge clk);
    check("clear_y_addr", 32'(lut_y_addr), 32'd0);
    do_sample(1, 8'd200, 8'd0, 8'd50, 1'b0);
    do_sample(1, 8'd200, 8'd50, 8'd87, 1'b1);
    do_sample(1, 8'd200, 8'd0, 8'd50, 1'b0);

    // Reset during OUTPUT drops the sample
    @(negedge clk);
    out_ready = 1'b0;
    in_valid[2] = 1'b1;
    in_data[23:16] = 8'd5;
    #1;
    check("rst6_grant", 32'(in_ready), 32'h4);
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst6_pre_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst6_out_valid", 32'(out_valid), 32'd0);
    check("rst6_busy", 32'(busy), 32'd0);
    check("rst6_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    do_sample(0, 8'd200, 8'd0, 8'd50, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
